// File: rtl/dac_sample_feeder.sv
// Playback stage feeding the I2S DAC serializer: fetches 16-bit PCM samples
// over a req/ack port and presents one sample per LRC frame, with skip/repeat speed control.
module dac_sample_feeder #(
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned SPEED_W = 3
) (
    input  logic                clk_n,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                fast,
    input  logic [SPEED_W-1:0]  speed,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                daclrc,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_ack,
    output logic [15:0]         data,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READY,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic                 s1_q, s2_q, s3_q;
    logic                 ev;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [SPEED_W-1:0]   rep_cnt_q, rep_cnt_d;
    logic [15:0]          staged_q, staged_d;
    logic [15:0]          data_q, data_d;
    logic                 mem_req_q, mem_req_d;
    logic                 done_q, done_d;
    logic                 underrun_q, underrun_d;

    logic [SPEED_W-1:0]   spd;
    logic [ADDR_W:0]      next_addr;
    logic                 past_end;
    logic                 last_repeat;
    logic                 need_addr;

    // Frame event is the synchronised rising edge of daclrc.
    assign ev          = s2_q & ~s3_q;
    assign spd         = (speed == '0) ? SPEED_W'(1) : speed;
    assign past_end    = addr_q > end_addr;
    // A start address beyond the end still plays its single sample only once.
    assign last_repeat = (rep_cnt_q >= (spd - SPEED_W'(1))) | past_end;

    always_comb begin
        next_addr = {1'b0, addr_q} + (fast ? (ADDR_W+1)'(spd) : (ADDR_W+1)'(1));
        need_addr = fast | last_repeat;
    end

    always_ff @(posedge clk_n) begin
        if (rst) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            addr_q     <= '0;
            rep_cnt_q  <= '0;
            staged_q   <= '0;
            data_q     <= '0;
            mem_req_q  <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= daclrc;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            addr_q     <= addr_d;
            rep_cnt_q  <= rep_cnt_d;
            staged_q   <= staged_d;
            data_q     <= data_d;
            mem_req_q  <= mem_req_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rep_cnt_d  = rep_cnt_q;
        staged_d   = staged_q;
        data_d     = data_q;
        done_d     = 1'b0;
        underrun_d = underrun_q;

        if (stop) begin
            state_d = IDLE;
            data_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_d     = start_addr;
                        rep_cnt_d  = '0;
                        underrun_d = 1'b0;
                        state_d    = FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ack && mem_req_q) begin
                        staged_d = mem_rdata;
                        state_d  = READY;
                    end
                    if (ev) begin
                        underrun_d = 1'b1;
                    end
                end
                READY: begin
                    if (ev) begin
                        if (pause) begin
                            data_d = '0;
                        end else begin
                            data_d = staged_q;
                            if (!fast) begin
                                rep_cnt_d = last_repeat ? '0 : rep_cnt_q + SPEED_W'(1);
                            end
                            if (need_addr) begin
                                if (next_addr > {1'b0, end_addr}) begin
                                    state_d = DONE;
                                end else begin
                                    addr_d  = next_addr[ADDR_W-1:0];
                                    state_d = FETCH;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    if (ev) begin
                        data_d  = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Request tracks the FETCH state, so it drops on the edge that accepts the ack.
        mem_req_d = (state_d == FETCH);
    end

    always_comb begin
        busy     = (state_q != IDLE);
        mem_req  = mem_req_q;
        mem_addr = addr_q;
        data     = data_q;
        done     = done_q;
        underrun = underrun_q;
    end

endmodule
